// File: rtl/baby_video_pkg.sv
// Shared constants and types for the small-glyph video label blocks.
// The ACC label family uses a fixed 32x16 glyph split into two 16-column
// ROM halves that share one row/column address.
package baby_video_pkg;

  // Glyph geometry.
  localparam int GLYPH_W    = 32;
  localparam int GLYPH_H    = 16;
  localparam int GLYPH_HALF = 16;

  // Default raster coordinate widths.
  localparam int HPOS_W = 11;
  localparam int VPOS_W = 10;

  typedef logic [HPOS_W-1:0] hpos_t;
  typedef logic [VPOS_W-1:0] vpos_t;

  // Width of a pixel-replication sub-counter; never narrower than one bit
  // so SCALE=1 still gets a legal (constant zero) register.
  function automatic int sub_bits(input int scale);
    if (scale <= 1) begin
      return 1;
    end else begin
      return $clog2(scale);
    end
  endfunction

endpackage

// File: rtl/acc_label_scanner_if.sv
// Glyph ROM bus: the scanner presents a row/column address and the ROM
// answers combinationally with the left-half and right-half pixel bits.
interface acc_label_scanner_if;

  logic [3:0] glyph_x;  // column within a half (col[3:0])
  logic [3:0] glyph_y;  // glyph row
  logic       pixell;   // bit for glyph columns 0..15
  logic       pixelr;   // bit for glyph columns 16..31

  // Scanner side drives the address and reads the pixels.
  modport master (
    output glyph_x,
    output glyph_y,
    input  pixell,
    input  pixelr
  );

  // ROM side decodes the address and returns the pixels.
  modport slave (
    input  glyph_x,
    input  glyph_y,
    output pixell,
    output pixelr
  );

endinterface

// File: rtl/label_axis_counter.sv
// One axis of the label window tracker. A load restarts the walk at glyph
// index 0; each step advances a sub-pixel counter and, every SCALE steps,
// the glyph index. After the last replicated pixel of index LEN-1 the run
// flag drops and the index holds, so the index never wraps.
module label_axis_counter
  import baby_video_pkg::*;
#(
  parameter int SCALE = 2,
  parameter int LEN   = 32,
  parameter int IW    = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,     // pixel-rate enable, everything holds when low
  input  logic          load,   // restart the walk (wins over everything)
  input  logic          step,   // advance one replicated pixel while running
  input  logic          clr,    // abort the walk, index holds
  output logic          run,
  output logic [IW-1:0] idx,
  output logic          last    // currently on the final replicated pixel
);

  localparam int SW = sub_bits(SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);

  logic          run_q, run_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] sub_q, sub_d;
  logic          last_s;

  assign last_s = run_q && (idx_q == IDX_LAST) && (sub_q == SUB_LAST);

  // Next-state for the run flag, glyph index and replication sub-counter.
  always_comb begin
    run_d = run_q;
    idx_d = idx_q;
    sub_d = sub_q;
    if (en) begin
      if (load) begin
        run_d = 1'b1;
        idx_d = '0;
        sub_d = '0;
      end else if (clr) begin
        run_d = 1'b0;
      end else if (run_q && step) begin
        if (last_s) begin
          run_d = 1'b0;
        end else if (sub_q == SUB_LAST) begin
          sub_d = '0;
          idx_d = idx_q + IW'(1);
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end else begin
        run_d = run_q;
      end
    end else begin
      run_d = run_q;
    end
  end

  // Axis state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      idx_q <= '0;
      sub_q <= '0;
    end else begin
      run_q <= run_d;
      idx_q <= idx_d;
      sub_q <= sub_d;
    end
  end

  assign run  = run_q;
  assign idx  = idx_q;
  assign last = last_s;

endmodule

// File: rtl/acc_label_scanner.sv
// Raster front end for the ACC label. Tracks the label window with two
// axis counters (no dividers), addresses the glyph ROM straight from the
// counter registers, and registers the selected ROM half together with
// two-beat delayed copies of active and the syncs for the colour mixer.
module acc_label_scanner
  import baby_video_pkg::*;
#(
  parameter int HW      = HPOS_W,
  parameter int VW      = VPOS_W,
  parameter int LABEL_X = 100,
  parameter int LABEL_Y = 40,
  parameter int SCALE   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_en,
  input  logic [HW-1:0]             hpos,
  input  logic [VW-1:0]             vpos,
  input  logic                      active_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  acc_label_scanner_if.master       rom,
  output logic                      label_on,
  output logic                      active_out,
  output logic                      hsync_out,
  output logic                      vsync_out
);

  localparam logic [HW-1:0] LX = HW'(LABEL_X);
  localparam logic [VW-1:0] LY = VW'(LABEL_Y);
  localparam int COL_W  = $clog2(GLYPH_W);
  localparam int ROW_W  = $clog2(GLYPH_H);
  localparam int HALF_B = $clog2(GLYPH_HALF);

  // Axis control decoded from the incoming timing stream.
  logic h_load_s, h_clr_s;
  logic v_load_s, v_step_s;
  logic h_run_s, v_run_s;
  logic h_last_s, v_last_s;
  logic [COL_W-1:0] col_s;
  logic [ROW_W-1:0] row_s;

  // The horizontal walk starts on the first label column of a visible
  // line and is abandoned as soon as the visible area ends.
  assign h_load_s = (hpos == LX) && active_in;
  assign h_clr_s  = ~active_in;

  // The vertical walk advances once per line, on the line's first pixel.
  assign v_step_s = (hpos == '0);
  assign v_load_s = v_step_s && (vpos == LY);

  label_axis_counter #(
    .SCALE (SCALE),
    .LEN   (GLYPH_W)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .load  (h_load_s),
    .step  (1'b1),
    .clr   (h_clr_s),
    .run   (h_run_s),
    .idx   (col_s),
    .last  (h_last_s)
  );

  label_axis_counter #(
    .SCALE (SCALE),
    .LEN   (GLYPH_H)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .load  (v_load_s),
    .step  (v_step_s),
    .clr   (1'b0),
    .run   (v_run_s),
    .idx   (row_s),
    .last  (v_last_s)
  );

  // End-of-walk flags are not needed here; the run flags already encode them.
  logic unused_last_s;
  assign unused_last_s = h_last_s ^ v_last_s;

  // Stage A view of the label window, all taken from counter registers.
  logic in_win_s, half_s, rom_pix_s;
  assign in_win_s  = h_run_s & v_run_s;
  assign half_s    = col_s[HALF_B];
  assign rom_pix_s = half_s ? rom.pixelr : rom.pixell;

  assign rom.glyph_x = col_s[3:0];
  assign rom.glyph_y = row_s;

  // Delay-line flops: stage 1 aligns with the counters, stage 2 with label_on.
  logic act1_q, act1_d;
  logic hs1_q,  hs1_d;
  logic vs1_q,  vs1_d;
  logic act2_q, act2_d;
  logic hs2_q,  hs2_d;
  logic vs2_q,  vs2_d;
  logic label_q, label_d;

  // Next-state for the two-stage delay line and the lit-pixel register.
  always_comb begin
    act1_d  = act1_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    act2_d  = act2_q;
    hs2_d   = hs2_q;
    vs2_d   = vs2_q;
    label_d = label_q;
    if (pix_en) begin
      act1_d  = active_in;
      hs1_d   = hsync_in;
      vs1_d   = vsync_in;
      act2_d  = act1_q;
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;
      label_d = in_win_s & act1_q & rom_pix_s;
    end else begin
      label_d = label_q;
    end
  end

  // Delay-line and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      act2_q  <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      label_q <= 1'b0;
    end else begin
      act1_q  <= act1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      act2_q  <= act2_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      label_q <= label_d;
    end
  end

  assign label_on   = label_q;
  assign active_out = act2_q;
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;

endmodule

// File: tb/tb_acc_label_scanner.sv
// Bench for acc_label_scanner: a small raster (270x78, 168x74 visible)
// with random pix_en gaps, a mid-frame reset, a frozen pixel, and one
// visible line with active_in held low. A pixel-level model derived from
// the label geometry predicts every output; literal checks pin the model.
module tb_acc_label_scanner;
  import baby_video_pkg::*;

  localparam int LX = 100, LY = 40, S = 2;
  localparam int H_TOTAL = 270, H_VIS = 168, HS_START = 170, HS_LEN = 96;
  localparam int V_TOTAL = 78, V_VIS = 74, VS_START = 75, VS_LEN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pix_en, active_in, hsync_in, vsync_in;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic        label_on, active_out, hsync_out, vsync_out;

  acc_label_scanner_if rom_if ();
  logic [31:0] rom_rows [16];
  assign rom_if.pixell = rom_rows[rom_if.glyph_y][{1'b0, rom_if.glyph_x}];
  assign rom_if.pixelr = rom_rows[rom_if.glyph_y][{1'b1, rom_if.glyph_x}];

  acc_label_scanner #(
    .HW(11), .VW(10), .LABEL_X(LX), .LABEL_Y(LY), .SCALE(S)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hpos(hpos), .vpos(vpos),
    .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rom(rom_if.master), .label_on(label_on), .active_out(active_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  int errors = 0, checks = 0;
  bit run_checks = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Raster generator state, plus tags presented alongside each pixel.
  int cur_h = 0, cur_v = 0, frame = 0;
  int frame_s = 0;
  bit ar_s = 1'b0, did_reset = 1'b0;

  task automatic drive_timing();
    hpos      = 11'(cur_h);
    vpos      = 10'(cur_v);
    active_in = (cur_h < H_VIS) && (cur_v < V_VIS) && !(frame == 1 && cur_v == 42);
    hsync_in  = (cur_h >= HS_START) && (cur_h < HS_START + HS_LEN);
    vsync_in  = (cur_v >= VS_START) && (cur_v < VS_START + VS_LEN);
    frame_s   = frame;
    ar_s      = did_reset && (frame == 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_label_on"}, int'(label_on), 0);
    check({tag, "_active_out"}, int'(active_out), 0);
    check({tag, "_hsync_out"}, int'(hsync_out), 0);
    check({tag, "_vsync_out"}, int'(vsync_out), 0);
    check({tag, "_glyph_x"}, int'(rom_if.glyph_x), 0);
    check({tag, "_glyph_y"}, int'(rom_if.glyph_y), 0);
  endtask

  // Behavioural model: window membership from distance to the label origin.
  bit m_hok = 0, m_vok = 0;
  int m_col = 0, m_row = 0;
  bit m_act1 = 0, m_hs1 = 0, m_vs1 = 0;
  bit m_act2 = 0, m_hs2 = 0, m_vs2 = 0, m_label = 0;
  int c1_h, c1_v, c1_f, c2_h, c2_v, c2_f;
  bit c1_ar, c2_ar, c1_valid = 0, c2_valid = 0, beat_q = 0;

  // Model update on each clock edge that the DUT would act on.
  always @(posedge clk) begin
    int d;
    beat_q = 1'b0;
    if (reset) begin
      m_hok = 0; m_vok = 0; m_col = 0; m_row = 0;
      m_act1 = 0; m_hs1 = 0; m_vs1 = 0;
      m_act2 = 0; m_hs2 = 0; m_vs2 = 0; m_label = 0;
      c1_valid = 0; c2_valid = 0;
    end else if (pix_en) begin
      beat_q = 1'b1;
      m_label = m_hok && m_vok && m_act1 && rom_rows[m_row][m_col];
      m_act2 = m_act1; m_hs2 = m_hs1; m_vs2 = m_vs1;
      c2_h = c1_h; c2_v = c1_v; c2_f = c1_f; c2_ar = c1_ar; c2_valid = c1_valid;
      m_act1 = active_in; m_hs1 = hsync_in; m_vs1 = vsync_in;
      c1_h = int'(hpos); c1_v = int'(vpos); c1_f = frame_s; c1_ar = ar_s; c1_valid = 1;
      if (int'(hpos) == LX && active_in) begin
        m_hok = 1; m_col = 0;
      end else if (!active_in) begin
        m_hok = 0;
      end else if (m_hok) begin
        d = int'(hpos) - LX;
        if (d >= 32 * S) m_hok = 0;
        else m_col = d / S;
      end
      if (hpos == 11'd0) begin
        if (int'(vpos) == LY) begin
          m_vok = 1; m_row = 0;
        end else if (m_vok) begin
          d = int'(vpos) - LY;
          if (d >= 16 * S) m_vok = 0;
          else m_row = d / S;
        end
      end
    end
  end

  // Compare process: model vs DUT every cycle, plus literal pins.
  int hs_cnt = 0, vs_cnt = 0;
  always @(negedge clk) begin
    bit exp_lit;
    if (run_checks) begin
      check("label_on", int'(label_on), int'(m_label));
      check("active_out", int'(active_out), int'(m_act2));
      check("hsync_out", int'(hsync_out), int'(m_hs2));
      check("vsync_out", int'(vsync_out), int'(m_vs2));
      check("glyph_x", int'(rom_if.glyph_x), m_col % 16);
      check("glyph_y", int'(rom_if.glyph_y), m_row);
      if (beat_q && c1_valid && c1_f == 0 && c1_v == 42 && c1_h >= LX && c1_h < LX + 64)
        check("row1_glyph_x_step", int'(rom_if.glyph_x), ((c1_h - LX) / 2) % 16);
      if (beat_q && c2_valid) begin
        if (c2_f == 0 && c2_v == 42) begin
          exp_lit = (c2_h >= 112 && c2_h <= 127) || (c2_h >= 136 && c2_h <= 159);
          check("row1_label", int'(label_on), int'(exp_lit));
        end
        if (c2_h == 99 || c2_h == 164)
          check("h_edge_label", int'(label_on), 0);
        if (c2_v == 39 || c2_v == 70 || c2_v == 71 || c2_v == 72)
          check("v_edge_label", int'(label_on), 0);
        if ((c2_f == 0 && c2_ar) || (c2_f == 1 && c2_v < LY))
          check("post_reset_label", int'(label_on), 0);
        if (c2_f == 1 && c2_v == 42) begin
          check("inactive_line_label", int'(label_on), 0);
          check("inactive_line_active", int'(active_out), 0);
        end
      end
      if (beat_q) begin
        if (hsync_out) hs_cnt++;
        else if (hs_cnt > 0) begin
          check("hsync_width", hs_cnt, HS_LEN);
          hs_cnt = 0;
        end
        if (vsync_out) vs_cnt++;
        else if (vs_cnt > 0) begin
          check("vsync_width", vs_cnt, VS_LEN * H_TOTAL);
          vs_cnt = 0;
        end
      end
    end
  end

  // Stimulus: raster with random enable gaps and the directed events.
  initial begin
    int hold_left;
    hold_left = 3;
    reset = 1'b0;
    pix_en = 1'b0;
    for (int r = 0; r < 16; r++) rom_rows[r] = $urandom();
    rom_rows[1]  = 32'h3FFC_3FC0;
    rom_rows[15] = 32'h0000_0000;
    drive_timing();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("por");
    @(negedge clk);
    reset = 1'b0;
    run_checks = 1'b1;
    while (frame < 2) begin
      if (hold_left > 0 && frame == 0 && cur_v == 42 && cur_h == 130) begin
        pix_en = 1'b0;
        hold_left--;
      end else begin
        pix_en = ($urandom_range(0, 7) != 0);
      end
      @(posedge clk);
      if (pix_en) begin
        cur_h++;
        if (cur_h == H_TOTAL) begin
          cur_h = 0;
          cur_v++;
          if (cur_v == V_TOTAL) begin
            cur_v = 0;
            frame++;
          end
        end
      end
      @(negedge clk);
      drive_timing();
      if (!did_reset && frame == 0 && cur_v == 45 && cur_h == 120) begin
        #2 reset = 1'b1;
        pix_en = 1'b0;
        #1 check_all_zero("mid_reset");
        did_reset = 1'b1;
        ar_s = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
